// File: rtl/nic_pkg.sv
// nic_pkg: shared definitions for the NIC host agent.
//   - nic_state_t  : host-agent FSM state encoding
//   - nic_turn_t   : RX/TX arbitration token
//   - NIC_ADDR_*   : fixed NIC register map
//   - nic_access_t / access_for_state : NIC bus request issued in each state
package nic_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX_STAT = 3'd1,
        S_RX_CHK  = 3'd2,
        S_RX_RD   = 3'd3,
        S_RX_CAP  = 3'd4,
        S_TX_STAT = 3'd5,
        S_TX_CHK  = 3'd6,
        S_TX_WR   = 3'd7
    } nic_state_t;

    typedef enum logic {
        TURN_RX = 1'b0,
        TURN_TX = 1'b1
    } nic_turn_t;

    localparam logic [1:0] NIC_ADDR_RX_BUF  = 2'b00;
    localparam logic [1:0] NIC_ADDR_RX_STAT = 2'b01;
    localparam logic [1:0] NIC_ADDR_TX_BUF  = 2'b10;
    localparam logic [1:0] NIC_ADDR_TX_STAT = 2'b11;

    typedef struct packed {
        logic       en;
        logic       wr;
        logic [1:0] addr;
    } nic_access_t;

    // Bus request presented to the NIC while the FSM sits in state s.
    function automatic nic_access_t access_for_state(input nic_state_t s);
        nic_access_t acc;
        acc = '{en: 1'b0, wr: 1'b0, addr: 2'b00};
        case (s)
            S_RX_STAT: acc = '{en: 1'b1, wr: 1'b0, addr: NIC_ADDR_RX_STAT};
            S_RX_RD:   acc = '{en: 1'b1, wr: 1'b0, addr: NIC_ADDR_RX_BUF};
            S_TX_STAT: acc = '{en: 1'b1, wr: 1'b0, addr: NIC_ADDR_TX_STAT};
            S_TX_WR:   acc = '{en: 1'b1, wr: 1'b1, addr: NIC_ADDR_TX_BUF};
            default:   acc = '{en: 1'b0, wr: 1'b0, addr: 2'b00};
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO used as the host transmit queue.
// Pointers carry one extra MSB so full and empty are distinguished
// without a separate occupancy counter.
//   i_clk, i_rst_n      : clock, async active-low reset (pointers only)
//   i_push, i_push_data : write request (ignored when full)
//   i_pop               : drop head entry (ignored when empty)
//   o_head              : current head entry
//   o_full, o_empty     : occupancy flags
// DEPTH must be a power of two, at least 2.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A full queue refuses pushes even when a pop frees a slot this cycle.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;
    assign o_head = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/nic_host_agent.sv
// nic_host_agent: bridges a host packet interface to a polled NIC
// register interface, alternating between draining the NIC receive
// buffer and pushing queued host packets into the NIC transmit buffer.
//
// Ports
//   clk, reset          : rising-edge clock, async active-low reset
//   tx_valid/tx_data    : host offers a packet (accepted when tx_ready)
//   tx_ready            : transmit queue not full
//   rx_valid/rx_data    : received packet held for the host
//   rx_ready            : host consumes rx_data
//   addr, d_in          : NIC register select and write data
//   d_out               : NIC read data, valid the cycle after a read
//   nicEn, nicEnWR      : NIC access enable, 1 = write / 0 = read
//   tx_count, rx_count  : packets written to / read from the NIC (wrap)
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | arbitrate between RX poll and TX send
// S_RX_STAT | read NIC rx status
// S_RX_CHK  | inspect rx status (d_out[0] = packet available)
// S_RX_RD   | read NIC rx buffer
// S_RX_CAP  | rx buffer data on d_out; load holding register
// S_TX_STAT | read NIC tx status
// S_TX_CHK  | inspect tx status (d_out[0] = NIC tx buffer full)
// S_TX_WR   | write queue head into NIC tx buffer
module nic_host_agent #(
    parameter int PACKET_WIDTH = 64,
    parameter int TXQ_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_valid,
    input  logic [PACKET_WIDTH-1:0] tx_data,
    output logic                    tx_ready,
    output logic                    rx_valid,
    output logic [PACKET_WIDTH-1:0] rx_data,
    input  logic                    rx_ready,
    output logic [1:0]              addr,
    output logic [PACKET_WIDTH-1:0] d_in,
    input  logic [PACKET_WIDTH-1:0] d_out,
    output logic                    nicEn,
    output logic                    nicEnWR,
    output logic [15:0]             tx_count,
    output logic [15:0]             rx_count
);

    import nic_pkg::*;

    nic_state_t              r_state;
    nic_state_t              w_state_nxt;
    nic_turn_t               r_turn;
    nic_turn_t               w_turn_nxt;
    nic_access_t             w_acc_nxt;

    logic                    r_nic_en;
    logic                    r_nic_wr;
    logic [1:0]              r_addr;
    logic [PACKET_WIDTH-1:0] r_d_in;
    logic                    r_rx_valid;
    logic [PACKET_WIDTH-1:0] r_rx_data;
    logic [15:0]             r_tx_count;
    logic [15:0]             r_rx_count;

    logic                    w_pop;
    logic                    w_rx_capture;
    logic                    w_q_full;
    logic                    w_q_empty;
    logic [PACKET_WIDTH-1:0] w_q_head;

    sync_fifo #(
        .WIDTH (PACKET_WIDTH),
        .DEPTH (TXQ_DEPTH)
    ) u_txq (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_push      (tx_valid),
        .i_push_data (tx_data),
        .i_pop       (w_pop),
        .o_head      (w_q_head),
        .o_full      (w_q_full),
        .o_empty     (w_q_empty)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_turn_nxt   = r_turn;
        w_pop        = 1'b0;
        w_rx_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                // RX is never polled while the holding register is occupied,
                // so a captured packet cannot be overwritten.
                if (!r_rx_valid && (r_turn == TURN_RX || w_q_empty))
                    w_state_nxt = S_RX_STAT;
                else if (!w_q_empty && (r_turn == TURN_TX || r_rx_valid))
                    w_state_nxt = S_TX_STAT;
            end
            S_RX_STAT: w_state_nxt = S_RX_CHK;
            S_RX_CHK: begin
                if (d_out[0]) begin
                    w_state_nxt = S_RX_RD;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_turn_nxt  = TURN_TX;
                end
            end
            S_RX_RD: w_state_nxt = S_RX_CAP;
            S_RX_CAP: begin
                w_rx_capture = 1'b1;
                w_turn_nxt   = TURN_TX;
                w_state_nxt  = S_IDLE;
            end
            S_TX_STAT: w_state_nxt = S_TX_CHK;
            S_TX_CHK: begin
                if (!d_out[0]) begin
                    // Pop on entry so the head is latched into d_in with
                    // the same edge that raises the write strobe.
                    w_state_nxt = S_TX_WR;
                    w_pop       = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_turn_nxt  = TURN_RX;
                end
            end
            S_TX_WR: begin
                w_turn_nxt  = TURN_RX;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_acc_nxt = access_for_state(w_state_nxt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_turn  <= TURN_RX;
        end else begin
            r_state <= w_state_nxt;
            r_turn  <= w_turn_nxt;
        end
    end

    // Bus outputs are registered from the next state so they line up
    // exactly with the state that owns them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_nic_en <= 1'b0;
            r_nic_wr <= 1'b0;
            r_addr   <= 2'b00;
            r_d_in   <= '0;
        end else begin
            r_nic_en <= w_acc_nxt.en;
            r_nic_wr <= w_acc_nxt.wr;
            r_addr   <= w_acc_nxt.addr;
            if (w_pop) r_d_in <= w_q_head;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else if (w_rx_capture) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= d_out;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_count <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_pop)        r_tx_count <= r_tx_count + 16'd1;
            if (w_rx_capture) r_rx_count <= r_rx_count + 16'd1;
        end
    end

    assign tx_ready = !w_q_full;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign addr     = r_addr;
    assign d_in     = r_d_in;
    assign nicEn    = r_nic_en;
    assign nicEnWR  = r_nic_wr;
    assign tx_count = r_tx_count;
    assign rx_count = r_rx_count;

endmodule

// File: tb/tb_nic_host_agent.sv
module tb_nic_host_agent;

    logic        clk;
    logic        rst_n;
    logic        tx_valid;
    logic [63:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [63:0] rx_data;
    logic        rx_ready;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicEnWR;
    logic [15:0] tx_count;
    logic [15:0] rx_count;

    int errors = 0;
    int checks = 0;

    // NIC register model
    logic        nic_tx_full = 1'b0;
    logic [63:0] nic_rx_q[$];
    logic [63:0] wr_log[$];
    int          rx_stat_reads = 0;

    nic_host_agent #(
        .PACKET_WIDTH (64),
        .TXQ_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .addr     (addr),
        .d_in     (d_in),
        .d_out    (d_out),
        .nicEn    (nicEn),
        .nicEnWR  (nicEnWR),
        .tx_count (tx_count),
        .rx_count (rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial d_out = '0;
    always @(posedge clk) begin
        if (nicEn && !nicEnWR) begin
            case (addr)
                2'b00: begin
                    if (nic_rx_q.size() > 0) begin
                        d_out <= nic_rx_q[0];
                        void'(nic_rx_q.pop_front());
                    end else begin
                        d_out <= '0;
                    end
                end
                2'b01: begin
                    d_out <= {63'd0, nic_rx_q.size() > 0};
                    rx_stat_reads++;
                end
                2'b11:   d_out <= {63'd0, nic_tx_full};
                default: d_out <= '0;
            endcase
        end
        if (nicEn && nicEnWR && addr == 2'b10) wr_log.push_back(d_in);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_acc(input logic [1:0] a, input logic wr, input string tag);
        int n = 0;
        while (!(nicEn === 1'b1 && addr === a && nicEnWR === wr) && n < 60) begin
            tick();
            n++;
        end
        check(tag, 64'(n < 60), 64'd1);
    endtask

    int s0;
    int p2;
    int n_wr;
    int k;

    initial begin
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        rx_ready = 1'b0;
        #2;
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
        check("rst_rx_valid", 64'(rx_valid), 64'd0);
        check("rst_rx_data", rx_data, 64'd0);
        check("rst_nicEn", 64'(nicEn), 64'd0);
        check("rst_nicEnWR", 64'(nicEnWR), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_d_in", d_in, 64'd0);
        check("rst_tx_count", 64'(tx_count), 64'd0);
        check("rst_rx_count", 64'(rx_count), 64'd0);

        // Release reset with a packet offered; first edge leaves IDLE for RX_STAT.
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 64'hA5;
        tick();
        tx_valid = 1'b0;
        check("first_edge_nicEn", 64'(nicEn), 64'd1);
        check("first_edge_addr", 64'(addr), 64'd1);

        // Single TX: TX_STAT, TX_CHK, TX_WR
        wait_acc(2'b11, 1'b0, "tx_stat_seen");
        tick();
        check("tx_chk_nicEn", 64'(nicEn), 64'd0);
        tick();
        check("tx_wr_nicEn", 64'(nicEn), 64'd1);
        check("tx_wr_nicEnWR", 64'(nicEnWR), 64'd1);
        check("tx_wr_addr", 64'(addr), 64'd2);
        check("tx_wr_d_in", d_in, 64'hA5);
        check("tx_count_1", 64'(tx_count), 64'd1);
        tick();
        check("tx_wr_logged", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() > 0) check("tx_wr_data", wr_log[0], 64'hA5);
        check("tx_after_wr_nicEn", 64'(nicEn), 64'd0);

        // Single RX: 4 cycles from RX_STAT to rx_valid
        nic_rx_q.push_back(64'h1234);
        wait_acc(2'b01, 1'b0, "rx_stat_seen");
        tick();
        check("rx_chk_nicEn", 64'(nicEn), 64'd0);
        tick();
        check("rx_rd_nicEn", 64'(nicEn), 64'd1);
        check("rx_rd_addr", 64'(addr), 64'd0);
        tick();
        check("rx_cap_not_yet", 64'(rx_valid), 64'd0);
        tick();
        check("rx_valid_set", 64'(rx_valid), 64'd1);
        check("rx_data_1234", rx_data, 64'h1234);
        check("rx_count_1", 64'(rx_count), 64'd1);

        // Holding register occupied: no RX status polls
        nic_rx_q.push_back(64'h5678);
        s0 = rx_stat_reads;
        repeat (12) tick();
        check("no_poll_while_held", 64'(rx_stat_reads), 64'(s0));
        check("rx_data_stable", rx_data, 64'h1234);
        check("rx_valid_held", 64'(rx_valid), 64'd1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx_valid_cleared", 64'(rx_valid), 64'd0);
        wait_acc(2'b01, 1'b0, "rx_poll_resumed");
        repeat (4) tick();
        check("rx_data_5678", rx_data, 64'h5678);
        check("rx_count_2", 64'(rx_count), 64'd2);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx_valid_cleared2", 64'(rx_valid), 64'd0);

        // Queue fill with NIC tx full
        nic_tx_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1'b1;
            tx_data  = 64'h100 + 64'(i);
            check("txq_accept", 64'(tx_ready), 64'd1);
            tick();
        end
        tx_data = 64'h104;
        check("txq_full_after_4", 64'(tx_ready), 64'd0);
        tick();
        check("txq_full_hold", 64'(tx_ready), 64'd0);
        tx_valid = 1'b0;
        s0 = rx_stat_reads;
        repeat (12) tick();
        check("no_write_nic_full", 64'(wr_log.size()), 64'd1);
        check("rx_polls_while_full", 64'(rx_stat_reads > s0), 64'd1);

        nic_tx_full = 1'b0;
        p2 = -1;
        k  = 0;
        while (wr_log.size() < 5 && k < 200) begin
            tick();
            k++;
            if (wr_log.size() == 2 && p2 < 0) p2 = rx_stat_reads;
        end
        check("four_writes", 64'(wr_log.size()), 64'd5);
        if (wr_log.size() == 5) begin
            for (int i = 0; i < 4; i++)
                check("write_order", wr_log[i+1], 64'h100 + 64'(i));
        end
        check("rx_poll_between_writes", 64'(rx_stat_reads - p2), 64'd3);
        check("tx_count_5", 64'(tx_count), 64'd5);
        check("txq_ready_after_drain", 64'(tx_ready), 64'd1);

        // Reset in the middle of TX_WR
        tx_valid = 1'b1;
        tx_data  = 64'hDEAD;
        tick();
        tx_data  = 64'hBEEF;
        tick();
        tx_valid = 1'b0;
        wait_acc(2'b10, 1'b1, "tx_wr_before_reset");
        n_wr = wr_log.size();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_nicEn", 64'(nicEn), 64'd0);
        check("rst_mid_nicEnWR", 64'(nicEnWR), 64'd0);
        check("rst_mid_tx_count", 64'(tx_count), 64'd0);
        check("rst_mid_rx_count", 64'(rx_count), 64'd0);
        check("rst_mid_d_in", d_in, 64'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) tick();
        check("no_write_after_reset", 64'(wr_log.size()), 64'(n_wr));
        check("tx_count_after_reset", 64'(tx_count), 64'd0);

        // Counter wrap
        force dut.r_tx_count = 16'hFFFF;
        #1;
        release dut.r_tx_count;
        check("tx_count_preset", 64'(tx_count), 64'hFFFF);
        tx_valid = 1'b1;
        tx_data  = 64'h77;
        tick();
        tx_valid = 1'b0;
        wait_acc(2'b10, 1'b1, "wrap_write_seen");
        check("tx_count_wrap", 64'(tx_count), 64'd0);
        check("wrap_d_in", d_in, 64'h77);
        tick();
        if (wr_log.size() > 0) check("wrap_write_data", wr_log[wr_log.size()-1], 64'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
